// File: rtl/pdi_block_sequencer_pkg.sv
// Shared constants and state encoding for the PDI block sequencer.
// Header layout: [31:28] type, [25] eot, [24] last, [15:0] byte length.
package pdi_block_sequencer_pkg;

    localparam int BUSW         = 32;
    localparam int CNTW         = 2;

    localparam int HDR_TYPE_MSB = 31;
    localparam int HDR_EOT_BIT  = 25;
    localparam int HDR_LAST_BIT = 24;
    localparam int HDR_LEN_MSB  = 15;

    localparam int BLK_BYTES    = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_FILL = 2'd2
    } state_t;

endpackage

// File: rtl/pdi_block_sequencer_if.sv
// Valid/ready word stream used for the PDI input and the padding_mux feed.
interface pdi_block_sequencer_if
    import pdi_block_sequencer_pkg::*;
#(
    parameter int W = BUSW
);

    logic [W-1:0] data;
    logic         valid;
    logic         ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);

endinterface

// File: rtl/pdi_block_sequencer.sv
// Slices PDI segments into 4-word blocks for padding_mux, filling short tails with zero words.
// Optional: EMPTY_SEG_PAD_EN turns a length-0 segment into one all-zero padded block.
module pdi_block_sequencer
    import pdi_block_sequencer_pkg::*;
#(
    parameter int BUSW = pdi_block_sequencer_pkg::BUSW,
    parameter int CNTW = pdi_block_sequencer_pkg::CNTW
) (
    input  logic                  clk,
    input  logic                  rst,
    pdi_block_sequencer_if.slave  pdi,
    pdi_block_sequencer_if.master blk,
    output logic [CNTW-1:0]       cnt,
    output logic [3:0]            seglen,
    output logic                  pad,
    output logic                  last,
    output logic                  blk_last,
    output logic [3:0]            seg_type,
    output logic                  seg_eot,
    output logic                  seg_last,
    output logic                  seg_done
);

    state_t            state;
    logic [15:0]       rem;
    logic              empty_done;
    logic              cnt_max;
    logic              data_xfer;
    logic [BUSW-1:0]   fwd_data;
    logic [15:0]       hdr_len;

    function automatic logic [15:0] sat_sub_blk(input logic [15:0] r);
        return (r > 16'(BLK_BYTES)) ? (r - 16'(BLK_BYTES)) : 16'd0;
    endfunction

    // Index of the last data word of a partial block: ceil(r/4)-1, valid for r in 1..15.
    function automatic logic [CNTW-1:0] tail_last_idx(input logic [3:0] r4);
        logic [3:0] t;
        t = r4 - 4'd1;
        return CNTW'(t >> 2);
    endfunction

    assign cnt_max   = (cnt == {CNTW{1'b1}});
    assign data_xfer = pdi.valid && blk.ready;
    assign hdr_len   = pdi.data[HDR_LEN_MSB:0];
    assign blk.data  = fwd_data;

    always_comb begin
        pad      = (rem < 16'(BLK_BYTES));
        seglen   = pad ? rem[3:0] : 4'd0;
        blk_last = (rem <= 16'(BLK_BYTES));
        last     = pad && cnt_max;

        pdi.ready = 1'b0;
        blk.valid = 1'b0;
        fwd_data  = '0;
        seg_done  = empty_done;

        case (state)
            ST_IDLE: begin
                pdi.ready = !empty_done;
            end
            ST_DATA: begin
                blk.valid = pdi.valid;
                pdi.ready = blk.ready;
                fwd_data  = pdi.data;
                seg_done  = data_xfer && cnt_max && blk_last;
            end
            ST_FILL: begin
                blk.valid = 1'b1;
                seg_done  = blk.ready && cnt_max;
            end
            default: ;
        endcase

        if (rst) begin
            pdi.ready = 1'b0;
            blk.valid = 1'b0;
            seg_done  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            rem        <= '0;
            seg_type   <= '0;
            seg_eot    <= 1'b0;
            seg_last   <= 1'b0;
            empty_done <= 1'b0;
        end else begin
            empty_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pdi.valid && pdi.ready) begin
                        seg_type <= pdi.data[HDR_TYPE_MSB -: 4];
                        seg_eot  <= pdi.data[HDR_EOT_BIT];
                        seg_last <= pdi.data[HDR_LAST_BIT];
                        rem      <= hdr_len;
                        cnt      <= '0;
                        if (hdr_len != 16'd0) begin
                            state <= ST_DATA;
                        end else begin
`ifdef EMPTY_SEG_PAD_EN
                            state <= ST_FILL;
`else
                            empty_done <= 1'b1;
`endif
                        end
                    end
                end
                ST_DATA: begin
                    if (data_xfer) begin
                        if (cnt_max) begin
                            cnt <= '0;
                            rem <= sat_sub_blk(rem);
                            if (blk_last)
                                state <= ST_IDLE;
                        end else begin
                            cnt <= cnt + CNTW'(1);
                            // Tail words are done mid-block: pad out the rest with zeros.
                            if (pad && (cnt == tail_last_idx(rem[3:0])))
                                state <= ST_FILL;
                        end
                    end
                end
                ST_FILL: begin
                    if (blk.ready) begin
                        if (cnt_max) begin
                            cnt   <= '0;
                            state <= ST_IDLE;
                        end else begin
                            cnt <= cnt + CNTW'(1);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pdi_block_sequencer.sv
// Directed bench for pdi_block_sequencer with hand-computed per-word expectations.
module tb_pdi_block_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] cnt;
    logic [3:0] seglen;
    logic       pad;
    logic       last;
    logic       blk_last;
    logic [3:0] seg_type;
    logic       seg_eot;
    logic       seg_last;
    logic       seg_done;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    pdi_block_sequencer_if #(.W(32)) pdi_if ();
    pdi_block_sequencer_if #(.W(32)) blk_if ();

    pdi_block_sequencer dut (
        .clk      (clk),
        .rst      (rst),
        .pdi      (pdi_if),
        .blk      (blk_if),
        .cnt      (cnt),
        .seglen   (seglen),
        .pad      (pad),
        .last     (last),
        .blk_last (blk_last),
        .seg_type (seg_type),
        .seg_eot  (seg_eot),
        .seg_last (seg_last),
        .seg_done (seg_done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic hdr(input logic [15:0] len, input logic [3:0] ty,
                       input logic eot, input logic lst);
        // Ignored header bits carry junk to show they are masked.
        pdi_if.data  = {ty, 2'b11, eot, lst, 8'hA5, len};
        pdi_if.valid = 1'b1;
        blk_if.ready = 1'b1;
        #1;
        chk("hdr_pready", pdi_if.ready, 1);
        chk("hdr_bvalid", blk_if.valid, 0);
        tick();
        pdi_if.valid = 1'b0;
        pdi_if.data  = '0;
        chk("hdr_type", seg_type, ty);
        chk("hdr_eot", seg_eot, eot);
        chk("hdr_last", seg_last, lst);
    endtask

    task automatic beat(input logic [31:0] d, input logic v, input logic r,
                        input logic ev, input logic [31:0] ed, input int ec,
                        input logic epad, input int esl, input logic eblast,
                        input logic edone, input logic epr);
        pdi_if.data  = d;
        pdi_if.valid = v;
        blk_if.ready = r;
        #1;
        chk("bvalid", blk_if.valid, ev);
        if (ev) chk("bdata", blk_if.data, ed);
        chk("cnt", cnt, ec);
        chk("pad", pad, epad);
        chk("seglen", seglen, esl);
        chk("last", last, epad && (ec == 3));
        chk("blk_last", blk_last, eblast);
        chk("seg_done", seg_done, edone);
        chk("pready", pdi_if.ready, epr);
        tick();
    endtask

    task automatic idle_chk();
        pdi_if.valid = 1'b0;
        blk_if.ready = 1'b1;
        #1;
        chk("idle_pready", pdi_if.ready, 1);
        chk("idle_bvalid", blk_if.valid, 0);
        chk("idle_done", seg_done, 0);
        chk("idle_cnt", cnt, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst          = 1'b1;
        pdi_if.valid = 1'b1;
        pdi_if.data  = '0;
        blk_if.ready = 1'b1;
        tick();
        chk("rst_pready", pdi_if.ready, 0);
        chk("rst_bvalid", blk_if.valid, 0);
        tick();
        rst          = 1'b0;
        pdi_if.valid = 1'b0;
        #1;
        chk("rst_cnt", cnt, 0);
        chk("rst_seglen", seglen, 0);
        chk("rst_type", seg_type, 0);
        chk("rst_eot", seg_eot, 0);
        chk("rst_last", seg_last, 0);
        chk("rst_done", seg_done, 0);
        chk("rst_bvalid2", blk_if.valid, 0);
        chk("rst_pready2", pdi_if.ready, 1);

        // len=32: two full blocks, no padding.
        hdr(16'd32, 4'h5, 1'b0, 1'b1);
        for (int k = 0; k < 8; k++)
            beat(32'hA000_0000 + k, 1, 1, 1, 32'hA000_0000 + k, k % 4, 0, 0, k >= 4, k == 7, 1);
        idle_chk();

        // len=5: two data words, two filler words.
        hdr(16'd5, 4'h1, 1'b1, 1'b0);
        beat(32'h1122_3344, 1, 1, 1, 32'h1122_3344, 0, 1, 5, 1, 0, 1);
        beat(32'h5500_0000, 1, 1, 1, 32'h5500_0000, 1, 1, 5, 1, 0, 1);
        beat(32'hDEAD_BEEF, 1, 1, 1, 32'h0, 2, 1, 5, 1, 0, 0);
        beat(32'hDEAD_BEEF, 1, 1, 1, 32'h0, 3, 1, 5, 1, 1, 0);
        idle_chk();

        // len=20: one full block, then one data word plus three fillers.
        hdr(16'd20, 4'h2, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++)
            beat(32'hC000_0000 + k, 1, 1, 1, 32'hC000_0000 + k, k, 0, 0, 0, 0, 1);
        beat(32'hC000_0004, 1, 1, 1, 32'hC000_0004, 0, 1, 4, 1, 0, 1);
        beat(32'h0BAD_0BAD, 1, 1, 1, 32'h0, 1, 1, 4, 1, 0, 0);
        beat(32'h0BAD_0BAD, 1, 1, 1, 32'h0, 2, 1, 4, 1, 0, 0);
        beat(32'h0BAD_0BAD, 1, 1, 1, 32'h0, 3, 1, 4, 1, 1, 0);
        idle_chk();

        // len=16 with blk_ready toggling: cnt only moves on handshakes.
        hdr(16'd16, 4'h3, 1'b1, 1'b1);
        beat(32'hB000_0000, 1, 1, 1, 32'hB000_0000, 0, 0, 0, 1, 0, 1);
        beat(32'hB000_0001, 1, 0, 1, 32'hB000_0001, 1, 0, 0, 1, 0, 0);
        beat(32'hB000_0001, 1, 1, 1, 32'hB000_0001, 1, 0, 0, 1, 0, 1);
        beat(32'hB000_0002, 1, 0, 1, 32'hB000_0002, 2, 0, 0, 1, 0, 0);
        beat(32'hB000_0002, 1, 1, 1, 32'hB000_0002, 2, 0, 0, 1, 0, 1);
        beat(32'hB000_0003, 1, 0, 1, 32'hB000_0003, 3, 0, 0, 1, 0, 0);
        beat(32'hB000_0003, 1, 1, 1, 32'hB000_0003, 3, 0, 0, 1, 1, 1);
        idle_chk();

        // len=0: empty segment.
        hdr(16'd0, 4'h7, 1'b0, 1'b1);
`ifdef EMPTY_SEG_PAD_EN
        for (int c = 0; c < 4; c++)
            beat(32'h0, 0, 1, 1, 32'h0, c, 1, 0, 1, c == 3, 0);
`else
        beat(32'h0, 0, 1, 0, 32'h0, 0, 1, 0, 1, 1, 0);
        beat(32'h0, 0, 1, 0, 32'h0, 0, 1, 0, 1, 0, 1);
`endif
        idle_chk();

        // len=48, reset at cnt=2 of the second block, then len=4.
        hdr(16'd48, 4'h9, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++)
            beat(32'hE000_0000 + k, 1, 1, 1, 32'hE000_0000 + k, k, 0, 0, 0, 0, 1);
        beat(32'hE000_0004, 1, 1, 1, 32'hE000_0004, 0, 0, 0, 0, 0, 1);
        beat(32'hE000_0005, 1, 1, 1, 32'hE000_0005, 1, 0, 0, 0, 0, 1);
        rst          = 1'b1;
        pdi_if.data  = 32'hE000_0006;
        pdi_if.valid = 1'b1;
        blk_if.ready = 1'b1;
        #1;
        chk("midrst_cnt_before", cnt, 2);
        chk("midrst_pready", pdi_if.ready, 0);
        chk("midrst_bvalid", blk_if.valid, 0);
        tick();
        rst          = 1'b0;
        pdi_if.valid = 1'b0;
        #1;
        chk("postrst_bvalid", blk_if.valid, 0);
        chk("postrst_cnt", cnt, 0);
        chk("postrst_pready", pdi_if.ready, 1);
        chk("postrst_type", seg_type, 0);
        hdr(16'd4, 4'h4, 1'b0, 1'b0);
        beat(32'hF00D_F00D, 1, 1, 1, 32'hF00D_F00D, 0, 1, 4, 1, 0, 1);
        beat(32'h1234_5678, 1, 1, 1, 32'h0, 1, 1, 4, 1, 0, 0);
        beat(32'h1234_5678, 1, 1, 1, 32'h0, 2, 1, 4, 1, 0, 0);
        beat(32'h1234_5678, 1, 1, 1, 32'h0, 3, 1, 4, 1, 1, 0);
        idle_chk();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
